// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C write arbiter: FSM state encoding,
// command word width and a one-hot decoder.
package i2c_arb_pkg;

  localparam int CMD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_t;

  // Supports up to 8 requesters; callers cast the result to their own width.
  function automatic logic [7:0] onehot_idx(input logic [2:0] idx);
    onehot_idx = 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_gnt,
// wrapping back to requester 0 after NUM_REQ-1.
module i2c_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = last_gnt;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit compare keeps the wrap correct when NUM_REQ is not a power of two.
      idx = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_wrt_arbiter.sv
// Round-robin arbiter sharing one I2C24Wrt master between NUM_REQ requesters,
// one 16-bit write per grant, with a watchdog that forces an error completion.
module i2c_wrt_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int               NUM_REQ = 4,
  parameter int               TMO_W   = 18,
  parameter logic [TMO_W-1:0] TMO_MAX = 18'h3FFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       cmplt,
  output logic                     cmplt_err,
  output logic                     tmo,
  output logic                     busy,
  output logic                     mst_wrt,
  output logic [CMD_W-1:0]         mst_data16,
  input  logic                     mst_done,
  input  logic                     mst_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] last_gnt;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [TMO_W-1:0] wd;

  i2c_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req     (req),
    .last_gnt(last_gnt),
    .winner  (pick),
    .any_req (any_req)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_gnt   <= IDX_W'(NUM_REQ - 1);
      cur        <= '0;
      wd         <= '0;
      gnt        <= '0;
      cmplt      <= '0;
      cmplt_err  <= 1'b0;
      tmo        <= 1'b0;
      busy       <= 1'b0;
      mst_wrt    <= 1'b0;
      mst_data16 <= '0;
    end else begin
      cmplt     <= '0;
      cmplt_err <= 1'b0;
      tmo       <= 1'b0;
      mst_wrt   <= 1'b0;

      case (state)
        IDLE: begin
          // gnt is still high during the cmplt cycle and drops (or moves) here.
          gnt <= '0;
          if (any_req) begin
            state      <= ISSUE;
            cur        <= pick;
            gnt        <= NUM_REQ'(onehot_idx(3'(pick)));
            mst_data16 <= req_data[CMD_W*pick +: CMD_W];
            mst_wrt    <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ISSUE: state <= WAIT_DONE;

        WAIT_DONE: begin
          // A done arriving on the watchdog's last cycle still counts as a real completion.
          if (mst_done || wd == TMO_MAX) begin
            state     <= IDLE;
            cmplt     <= gnt;
            cmplt_err <= mst_done ? mst_err : 1'b1;
            tmo       <= !mst_done;
            last_gnt  <= cur;
            wd        <= '0;
            busy      <= 1'b0;
          end else begin
            wd <= wd + TMO_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
